// File: rtl/vga_sync.sv
// VGA timing generator: pixel-rate divider, h/v position counters and
// glitch-free registered sync/blanking outputs aligned with the counters.
module vga_sync #(
   parameter int unsigned HD  = 640,
   parameter int unsigned HF  = 16,
   parameter int unsigned HR  = 96,
   parameter int unsigned HB  = 48,
   parameter int unsigned VD  = 480,
   parameter int unsigned VF  = 10,
   parameter int unsigned VR  = 2,
   parameter int unsigned VB  = 33,
   parameter int unsigned DIV = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   output logic       p_tick,
   output logic [9:0] pixel_x,
   output logic [9:0] pixel_y,
   output logic       video_on,
   output logic       hsync,
   output logic       vsync
);

   localparam int unsigned HT = HD + HF + HR + HB;
   localparam int unsigned VT = VD + VF + VR + VB;
   localparam int unsigned DW = (DIV > 1) ? $clog2(DIV) : 1;

   localparam logic [DW-1:0] DIV_MAX = DW'(DIV - 1);
   localparam logic [9:0]    H_MAX   = 10'(HT - 1);
   localparam logic [9:0]    V_MAX   = 10'(VT - 1);
   localparam logic [9:0]    H_VIS   = 10'(HD);
   localparam logic [9:0]    V_VIS   = 10'(VD);
   localparam logic [9:0]    HS_BEG  = 10'(HD + HF);
   localparam logic [9:0]    HS_END  = 10'(HD + HF + HR - 1);
   localparam logic [9:0]    VS_BEG  = 10'(VD + VF);
   localparam logic [9:0]    VS_END  = 10'(VD + VF + VR - 1);

   logic [DW-1:0] div_q, div_d;
   logic [9:0]    h_q, h_d;
   logic [9:0]    v_q, v_d;
   logic          hsync_q, hsync_d;
   logic          vsync_q, vsync_d;
   logic          video_on_q, video_on_d;
   logic          tick;

   always_comb begin
      tick       = en && (div_q == DIV_MAX);
      div_d      = div_q;
      h_d        = h_q;
      v_d        = v_q;
      hsync_d    = hsync_q;
      vsync_d    = vsync_q;
      video_on_d = video_on_q;

      if (en) begin
         div_d = tick ? '0 : div_q + DW'(1);
      end

      if (tick) begin
         if (h_q == H_MAX) begin
            h_d = '0;
            v_d = (v_q == V_MAX) ? '0 : v_q + 10'd1;
         end else begin
            h_d = h_q + 10'd1;
         end
      end

      // Decode from next-state counters so outputs change on the same edge as the position.
      if (en) begin
         hsync_d    = !((h_d >= HS_BEG) && (h_d <= HS_END));
         vsync_d    = !((v_d >= VS_BEG) && (v_d <= VS_END));
         video_on_d = (h_d < H_VIS) && (v_d < V_VIS);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         div_q      <= '0;
         h_q        <= '0;
         v_q        <= '0;
         hsync_q    <= 1'b1;
         vsync_q    <= 1'b1;
         video_on_q <= 1'b0;
      end else begin
         div_q      <= div_d;
         h_q        <= h_d;
         v_q        <= v_d;
         hsync_q    <= hsync_d;
         vsync_q    <= vsync_d;
         video_on_q <= video_on_d;
      end
   end

   assign p_tick   = tick;
   assign pixel_x  = h_q;
   assign pixel_y  = v_q;
   assign hsync    = hsync_q;
   assign vsync    = vsync_q;
   assign video_on = video_on_q;

endmodule

// File: tb/tb_vga_sync.sv
// Directed bench for vga_sync: line-level timing on a default instance,
// frame-level timing and wrap on a scaled-down instance.
module tb_vga_sync;

   logic       clk = 1'b0;
   logic       rst, en, rst_s, en_s;
   logic       p_tick, video_on, hsync, vsync;
   logic [9:0] x, y;
   logic       p_tick_s, video_on_s, hsync_s, vsync_s;
   logic [9:0] x_s, y_s;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   vga_sync dut (
      .clk(clk), .rst(rst), .en(en), .p_tick(p_tick),
      .pixel_x(x), .pixel_y(y), .video_on(video_on), .hsync(hsync), .vsync(vsync)
   );

   // Scaled timing: HT = 25, VT = 12, DIV = 2 -> frame of 600 clk.
   vga_sync #(
      .HD(16), .HF(2), .HR(3), .HB(4), .VD(6), .VF(1), .VR(2), .VB(3), .DIV(2)
   ) dut_s (
      .clk(clk), .rst(rst_s), .en(en_s), .p_tick(p_tick_s),
      .pixel_x(x_s), .pixel_y(y_s), .video_on(video_on_s), .hsync(hsync_s), .vsync(vsync_s)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end else begin
         $display("ok   %s: %0d", tag, obs);
      end
   endtask

   initial begin
      int cyc, hs_ticks, hs_bad, vo_bad, first_low_x, vo_fall_x, n, freeze_bad;
      bit seen_other, prev_vo;
      int t, t1, t2, vs_ticks, vs_bad, hs_bad_s, vo_bad_s;
      bit prev_in, in10, prev_wrap, wrap_seen;
      logic [9:0] wx, wy;
      logic wv, wh, wvs;

      rst = 1'b0; en = 1'b1; rst_s = 1'b0; en_s = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_x", 32'(x), 0);
      chk("rst_y", 32'(y), 0);
      chk("rst_p_tick", 32'(p_tick), 0);
      chk("rst_hsync", 32'(hsync), 1);
      chk("rst_vsync", 32'(vsync), 1);
      chk("rst_video_on", 32'(video_on), 0);

      rst = 1'b1;
      @(negedge clk);
      chk("edge1_video_on", 32'(video_on), 1);
      chk("edge1_p_tick", 32'(p_tick), 0);
      @(negedge clk);
      chk("edge2_p_tick", 32'(p_tick), 0);
      @(negedge clk);
      chk("cycle4_p_tick", 32'(p_tick), 1);
      chk("cycle4_x", 32'(x), 0);
      @(negedge clk);
      chk("edge4_x", 32'(x), 1);
      chk("edge4_p_tick", 32'(p_tick), 0);
      chk("edge4_hsync", 32'(hsync), 1);
      chk("edge4_vsync", 32'(vsync), 1);

      // One full line, from x=1 back to x=1.
      cyc = 0; hs_ticks = 0; hs_bad = 0; vo_bad = 0;
      first_low_x = -1; vo_fall_x = -1; seen_other = 0; prev_vo = 1'b1;
      while (cyc < 4000) begin
         @(negedge clk);
         cyc++;
         if (p_tick && !hsync) hs_ticks++;
         if (!hsync && first_low_x < 0) first_low_x = int'(x);
         if (prev_vo && !video_on && vo_fall_x < 0) vo_fall_x = int'(x);
         prev_vo = video_on;
         if (hsync !== !(x >= 656 && x <= 751)) hs_bad++;
         if (video_on !== (x < 640 && y < 480)) vo_bad++;
         if (x != 1) seen_other = 1;
         else if (seen_other) break;
      end
      chk("line_period_clk", 32'(cyc), 3200);
      chk("hsync_low_ticks", 32'(hs_ticks), 96);
      chk("hsync_first_low_x", 32'(first_low_x), 656);
      chk("video_on_fall_x", 32'(vo_fall_x), 640);
      chk("hsync_decode_errs", 32'(hs_bad), 0);
      chk("video_on_decode_errs", 32'(vo_bad), 0);
      chk("line_y", 32'(y), 1);

      // Freeze at x=655 in the slot where p_tick would fire.
      n = 0;
      while (x != 655 && n < 4000) begin @(negedge clk); n++; end
      chk("reach_x655", 32'(x), 655);
      repeat (3) @(negedge clk);
      chk("pre_freeze_p_tick", 32'(p_tick), 1);
      en = 1'b0;
      #1;
      chk("freeze_p_tick_now", 32'(p_tick), 0);
      freeze_bad = 0;
      repeat (10) begin
         @(negedge clk);
         if (x != 655 || y != 1 || p_tick || !hsync || video_on || !vsync) freeze_bad++;
      end
      chk("freeze_hold_errs", 32'(freeze_bad), 0);
      en = 1'b1;
      n = 0;
      while (x != 656 && n < 20) begin @(negedge clk); n++; end
      chk("resume_edges_to_656", 32'(n), 1);
      chk("resume_hsync", 32'(hsync), 0);

      // Asynchronous reset between edges while hsync is low.
      n = 0;
      while (x != 700 && n < 400) begin @(negedge clk); n++; end
      chk("pre_arst_hsync", 32'(hsync), 0);
      #2 rst = 1'b0;
      #1;
      chk("arst_x", 32'(x), 0);
      chk("arst_y", 32'(y), 0);
      chk("arst_hsync", 32'(hsync), 1);
      chk("arst_vsync", 32'(vsync), 1);
      chk("arst_video_on", 32'(video_on), 0);
      chk("arst_p_tick", 32'(p_tick), 0);

      // Scaled instance: one full frame plus the (24,11) -> (0,0) wrap.
      @(negedge clk);
      rst_s = 1'b1; en_s = 1'b1;
      t = 0; t1 = -1; t2 = -1; vs_ticks = 0; vs_bad = 0; hs_bad_s = 0; vo_bad_s = 0;
      prev_in = 0; prev_wrap = 0; wrap_seen = 0;
      wx = '1; wy = '1; wv = 1'b0; wh = 1'b0; wvs = 1'b0;
      while (t < 2000 && t2 < 0) begin
         @(negedge clk);
         t++;
         in10 = (x_s == 1 && y_s == 0);
         if (in10 && !prev_in) begin
            if (t1 < 0) t1 = t;
            else t2 = t;
         end
         prev_in = in10;
         if (t1 >= 0 && t2 < 0) begin
            if (p_tick_s && !vsync_s) vs_ticks++;
            if (vsync_s !== !(y_s >= 7 && y_s <= 8)) vs_bad++;
            if (hsync_s !== !(x_s >= 18 && x_s <= 20)) hs_bad_s++;
            if (video_on_s !== (x_s < 16 && y_s < 6)) vo_bad_s++;
         end
         if (prev_wrap) begin
            wrap_seen = 1; wx = x_s; wy = y_s; wv = video_on_s; wh = hsync_s; wvs = vsync_s;
         end
         prev_wrap = p_tick_s && x_s == 24 && y_s == 11;
      end
      chk("s_frame_period_clk", 32'(t2 - t1), 600);
      chk("s_vsync_low_ticks", 32'(vs_ticks), 50);
      chk("s_vsync_decode_errs", 32'(vs_bad), 0);
      chk("s_hsync_decode_errs", 32'(hs_bad_s), 0);
      chk("s_video_on_decode_errs", 32'(vo_bad_s), 0);
      chk("s_wrap_seen", 32'(wrap_seen), 1);
      chk("s_wrap_x", 32'(wx), 0);
      chk("s_wrap_y", 32'(wy), 0);
      chk("s_wrap_video_on", 32'(wv), 1);
      chk("s_wrap_hsync", 32'(wh), 1);
      chk("s_wrap_vsync", 32'(wvs), 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
